rgb2gray_stream: RTL and testbench

//   Streaming, pipelined RGB-to-grayscale converter for the Sobel front end.

---
 rtl/rgb2gray_stream.sv | 145 ++++++++++++++
 tb/tb_rgb2gray_stream.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/rgb2gray_stream.sv
// rtl/rgb2gray_stream.sv - pipelined RGB-to-gray stream converter with raster markers
module rgb2gray_stream #(
  parameter int H       = 200,
  parameter int W       = 160,
  parameter int DW      = 8,
  parameter int R_COEFF = 30,
  parameter int G_COEFF = 59,
  parameter int B_COEFF = 11,
  parameter int SHIFT   = 7,
  parameter int ROUND   = 0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          sync_clr,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_red,
  input  logic [DW-1:0] s_green,
  input  logic [DW-1:0] s_blue,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_gray,
  output logic          m_sof,
  output logic          m_eol,
  output logic          m_eof
);

  // Product width holds any 8-bit coefficient times a full-scale channel;
  // sum width adds two bits of headroom for three products plus rounding.
  localparam int PW = DW + 8;
  localparam int SW = DW + 10;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int RW = (H > 1) ? $clog2(H) : 1;

  localparam logic [PW-1:0] RC = PW'(R_COEFF);
  localparam logic [PW-1:0] GC = PW'(G_COEFF);
  localparam logic [PW-1:0] BC = PW'(B_COEFF);

  localparam logic [SW-1:0] RND  = (ROUND != 0) ? (SW'(1) << (SHIFT - 1)) : SW'(0);
  localparam logic [SW-1:0] MAXV = {{(SW-DW){1'b0}}, {DW{1'b1}}};

  localparam logic [CW-1:0] COL_LAST = CW'(W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);

  logic          ce;
  logic          accept;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          col_last;
  logic          row_last;

  logic          v1;
  logic [PW-1:0] p_red;
  logic [PW-1:0] p_green;
  logic [PW-1:0] p_blue;
  logic          sof1;
  logic          eol1;
  logic          eof1;

  logic [SW-1:0] sum;
  logic [SW-1:0] y;
  logic [DW-1:0] gray_next;

  // The whole pipeline advances together whenever the output slot is free or draining;
  // a stalled output freezes every stage so nothing is squeezed or lost.
  assign ce      = !m_valid || m_ready;
  assign s_ready = ce && !sync_clr;
  assign accept  = s_valid && s_ready;

  assign col_last = (col == COL_LAST);
  assign row_last = (row == ROW_LAST);

  // Raster position of the next accepted pixel; moves only on real input transfers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col <= '0;
      row <= '0;
    end else if (sync_clr) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        if (row_last) begin
          row <= '0;
        end else begin
          row <= row + RW'(1);
        end
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Stage 1: weighted channel products and the pixel's position markers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1      <= 1'b0;
      p_red   <= '0;
      p_green <= '0;
      p_blue  <= '0;
      sof1    <= 1'b0;
      eol1    <= 1'b0;
      eof1    <= 1'b0;
    end else if (sync_clr) begin
      v1 <= 1'b0;
    end else if (ce) begin
      v1      <= accept;
      p_red   <= PW'(s_red)   * RC;
      p_green <= PW'(s_green) * GC;
      p_blue  <= PW'(s_blue)  * BC;
      sof1    <= (col == '0) && (row == '0);
      eol1    <= col_last;
      eof1    <= col_last && row_last;
    end
  end

  // Sum, optional half-up rounding, scale down, clamp to the output range.
  always_comb begin
    sum       = SW'(p_red) + SW'(p_green) + SW'(p_blue) + RND;
    y         = sum >> SHIFT;
    gray_next = (y > MAXV) ? {DW{1'b1}} : y[DW-1:0];
  end

  // Stage 2: output register; holds its contents while downstream stalls.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_valid <= 1'b0;
      m_gray  <= '0;
      m_sof   <= 1'b0;
      m_eol   <= 1'b0;
      m_eof   <= 1'b0;
    end else if (sync_clr) begin
      m_valid <= 1'b0;
    end else if (ce) begin
      m_valid <= v1;
      m_gray  <= gray_next;
      m_sof   <= sof1;
      m_eol   <= eol1;
      m_eof   <= eof1;
    end
  end

endmodule

// File: tb/tb_rgb2gray_stream.sv
// tb/tb_rgb2gray_stream.sv - directed bench for rgb2gray_stream across four parameter sets
`timescale 1ns/1ps
module tb_rgb2gray_stream;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic sync_clr = 1'b0;
  logic s_valid = 1'b0;
  logic m_ready = 1'b1;
  logic [7:0] red = '0;
  logic [7:0] green = '0;
  logic [7:0] blue = '0;

  // Index 0: defaults, 1: rounding, 2: saturating coefficients, 3: 4x2 frame.
  logic [3:0] mv;
  logic [3:0] sr;
  logic [3:0] sof;
  logic [3:0] eol;
  logic [3:0] eof;
  logic [3:0][7:0] gray;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rgb2gray_stream u_def (
    .clk(clk), .rstn(rstn), .sync_clr(sync_clr), .s_valid(s_valid), .s_ready(sr[0]),
    .s_red(red), .s_green(green), .s_blue(blue), .m_valid(mv[0]), .m_ready(m_ready),
    .m_gray(gray[0]), .m_sof(sof[0]), .m_eol(eol[0]), .m_eof(eof[0]));

  rgb2gray_stream #(.ROUND(1)) u_rnd (
    .clk(clk), .rstn(rstn), .sync_clr(sync_clr), .s_valid(s_valid), .s_ready(sr[1]),
    .s_red(red), .s_green(green), .s_blue(blue), .m_valid(mv[1]), .m_ready(m_ready),
    .m_gray(gray[1]), .m_sof(sof[1]), .m_eol(eol[1]), .m_eof(eof[1]));

  rgb2gray_stream #(.R_COEFF(64), .G_COEFF(64), .B_COEFF(64)) u_sat (
    .clk(clk), .rstn(rstn), .sync_clr(sync_clr), .s_valid(s_valid), .s_ready(sr[2]),
    .s_red(red), .s_green(green), .s_blue(blue), .m_valid(mv[2]), .m_ready(m_ready),
    .m_gray(gray[2]), .m_sof(sof[2]), .m_eol(eol[2]), .m_eof(eof[2]));

  rgb2gray_stream #(.W(4), .H(2)) u_frm (
    .clk(clk), .rstn(rstn), .sync_clr(sync_clr), .s_valid(s_valid), .s_ready(sr[3]),
    .s_red(red), .s_green(green), .s_blue(blue), .m_valid(mv[3]), .m_ready(m_ready),
    .m_gray(gray[3]), .m_sof(sof[3]), .m_eol(eol[3]), .m_eof(eof[3]));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    s_valid = v;
    red     = r;
    green   = g;
    blue    = b;
  endtask

  // Single-pixel vectors with hand-computed results per instance.
  logic [7:0] vr [3] = '{8'd200, 8'd255, 8'd1};
  logic [7:0] vg [3] = '{8'd100, 8'd255, 8'd1};
  logic [7:0] vb [3] = '{8'd50,  8'd255, 8'd1};
  int exp_def [3] = '{97, 199, 0};
  int exp_rnd [3] = '{97, 199, 1};
  int exp_sat [3] = '{175, 255, 1};

  // Stream pixel i = (20i, 10i, 5i): default gray = floor(1245*i/128).
  int exp_stream [10] = '{0, 9, 19, 29, 38, 48, 58, 68, 77, 87};

  initial begin
    int in_idx;
    int out_idx;
    logic [7:0] prev_gray;
    logic prev_stall;

    // Reset held: outputs idle, s_ready reads 1.
    #1;
    check_eq("rst_m_valid", 32'(mv), 0);
    check_eq("rst_s_ready", 32'(sr[0]), 1);
    @(negedge clk);
    rstn = 1'b1;

    // Two pixels in flight, then asynchronous reset mid-cycle.
    @(negedge clk);
    drive(1'b1, 8'd10, 8'd10, 8'd10);
    @(negedge clk);
    @(negedge clk);
    drive(1'b0, 8'd0, 8'd0, 8'd0);
    #1;
    check_eq("inflight_m_valid", 32'(mv[0]), 1);
    rstn = 1'b0;
    #1;
    check_eq("async_rst_m_valid", 32'(mv), 0);
    @(negedge clk);
    rstn = 1'b1;

    // Latency of exactly two cycles and arithmetic per parameter set.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1'b1, vr[k], vg[k], vb[k]);
      #1;
      check_eq($sformatf("lat_s_ready_%0d", k), 32'(sr[0]), 1);
      @(negedge clk);
      drive(1'b0, 8'd0, 8'd0, 8'd0);
      check_eq($sformatf("lat1_m_valid_%0d", k), 32'(mv[0]), 0);
      @(negedge clk);
      check_eq($sformatf("lat2_m_valid_%0d", k), 32'(mv[0]), 1);
      check_eq($sformatf("def_gray_%0d", k), 32'(gray[0]), 32'(exp_def[k]));
      check_eq($sformatf("rnd_gray_%0d", k), 32'(gray[1]), 32'(exp_rnd[k]));
      check_eq($sformatf("sat_gray_%0d", k), 32'(gray[2]), 32'(exp_sat[k]));
      check_eq($sformatf("def_sof_%0d", k), 32'(sof[0]), (k == 0) ? 1 : 0);
    end

    // Clear counters before the framing run.
    @(negedge clk);
    sync_clr = 1'b1;
    @(negedge clk);
    sync_clr = 1'b0;

    // Continuous stream of 10 pixels, downstream stalled for cycles 4..8.
    in_idx = 0;
    out_idx = 0;
    prev_gray = '0;
    prev_stall = 1'b0;
    for (int cyc = 0; cyc < 60 && out_idx < 10; cyc++) begin
      m_ready = !(cyc >= 4 && cyc < 9);
      if (in_idx < 10) begin
        drive(1'b1, 8'(20 * in_idx), 8'(10 * in_idx), 8'(5 * in_idx));
      end else begin
        drive(1'b0, 8'd0, 8'd0, 8'd0);
      end
      #1;
      if (prev_stall) begin
        check_eq($sformatf("bp_hold_c%0d", cyc), 32'(gray[0]), 32'(prev_gray));
      end
      if (!m_ready && mv[0]) begin
        check_eq($sformatf("bp_s_ready_c%0d", cyc), 32'(sr[0]), 0);
      end
      if (mv[0] && m_ready) begin
        check_eq($sformatf("str_gray_%0d", out_idx), 32'(gray[0]), 32'(exp_stream[out_idx]));
        check_eq($sformatf("frm_gray_%0d", out_idx), 32'(gray[3]), 32'(exp_stream[out_idx]));
        check_eq($sformatf("frm_valid_%0d", out_idx), 32'(mv[3]), 1);
        check_eq($sformatf("frm_sof_%0d", out_idx), 32'(sof[3]), (out_idx == 0 || out_idx == 8) ? 1 : 0);
        check_eq($sformatf("frm_eol_%0d", out_idx), 32'(eol[3]), (out_idx == 3 || out_idx == 7) ? 1 : 0);
        check_eq($sformatf("frm_eof_%0d", out_idx), 32'(eof[3]), (out_idx == 7) ? 1 : 0);
        out_idx++;
      end
      if (s_valid && sr[0]) begin
        in_idx++;
      end
      prev_stall = mv[0] && !m_ready;
      prev_gray = gray[0];
      @(negedge clk);
    end
    check_eq("stream_no_loss", 32'(out_idx), 10);
    m_ready = 1'b1;

    // Pixel in flight dropped by sync_clr; s_ready low during the clear.
    drive(1'b1, 8'd255, 8'd255, 8'd255);
    @(negedge clk);
    drive(1'b1, 8'd255, 8'd255, 8'd255);
    sync_clr = 1'b1;
    #1;
    check_eq("clr_s_ready", 32'(sr[0]), 0);
    @(negedge clk);
    sync_clr = 1'b0;
    drive(1'b0, 8'd0, 8'd0, 8'd0);
    check_eq("clr_drop_a", 32'(mv), 0);
    @(negedge clk);
    check_eq("clr_drop_b", 32'(mv), 0);

    // First pixel after the clear restarts the frame.
    drive(1'b1, 8'd200, 8'd100, 8'd50);
    @(negedge clk);
    drive(1'b0, 8'd0, 8'd0, 8'd0);
    @(negedge clk);
    check_eq("post_clr_valid", 32'(mv[3]), 1);
    check_eq("post_clr_sof", 32'(sof[3]), 1);
    check_eq("post_clr_eol", 32'(eol[3]), 0);
    check_eq("post_clr_gray", 32'(gray[3]), 97);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
